// File: rtl/proc_core_param.sv
// proc_core_param: parametrised multi-cycle processor core.
// Holds the instruction register, a 2-bit timestep sequencer, an NREG x W
// register file, the A/G ALU registers and the internal bus. Operands are
// supplied through EXEC/D. BUSY and DONE report progress, and a combinational
// peek port reads the register file.
// Optional build macro FLAGS_EN adds {N,C,Z} flags that update whenever G loads.
module proc_core_param #(
    parameter int W    = 10,
    parameter int NREG = 4
) (
    input  logic                    CLK,
    input  logic                    CLRn,
    input  logic                    EXEC,
    input  logic [W-1:0]            D,
    input  logic [$clog2(NREG)-1:0] PEEK_ADDR,
    output logic [W-1:0]            PEEK_DATA,
    output logic [W-1:0]            BUS,
    output logic [1:0]              T,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [2:0]              FLAGS
);
    localparam int AW = $clog2(NREG);
    // Only the decoded fields of IR are kept; the ignored LSBs are never stored.
    localparam int IW = 4 + 2 * AW;

    generate
        if (NREG < 2 || (1 << AW) != NREG) begin : g_bad_nreg
            $error("NREG must be a power of 2 and at least 2");
        end
        if (W < IW) begin : g_bad_w
            $error("W must be at least 4 + 2*clog2(NREG)");
        end
    endgenerate

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_INV  = 4'd4;
    localparam logic [3:0] OP_FLP  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SUBI = 4'd7;

    tstep_e         t_q, t_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   g_q, g_d;
    logic [W-1:0]   regs_q [NREG];
    logic [W-1:0]   regs_d [NREG];
    logic           done_q, done_d;
    logic [W-1:0]   bus;
    logic [3:0]     op;
    logic [AW-1:0]  rx, ry;
    logic [W-1:0]   alu_b;

    assign op = ir_q[IW-1 -: 4];
    assign rx = ir_q[IW-5 -: AW];
    assign ry = ir_q[AW-1:0];
    // Immediate forms (op[2]=1) take their second operand from D.
    assign alu_b = op[2] ? D : regs_q[ry];

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = v[W-1-i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] add_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sub);
        return sub ? (x - y) : (x + y);
    endfunction

    // Sequencer: next timestep, register/ALU updates and bus source per step.
    always_comb begin
        t_d    = t_q;
        ir_d   = ir_q;
        a_d    = a_q;
        g_d    = g_q;
        regs_d = regs_q;
        done_d = 1'b0;
        bus    = '0;
        case (t_q)
            T0: begin
                if (EXEC) begin
                    ir_d = D[W-1 -: IW];
                    t_d  = T1;
                end
            end
            T1: begin
                case (op)
                    OP_LOAD: begin
                        bus = D;
                        if (EXEC) begin
                            regs_d[rx] = D;
                            t_d        = T0;
                            done_d     = 1'b1;
                        end
                    end
                    OP_MOV: begin
                        bus        = regs_q[ry];
                        regs_d[rx] = regs_q[ry];
                        t_d        = T0;
                        done_d     = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                        bus = regs_q[rx];
                        a_d = regs_q[rx];
                        t_d = T2;
                    end
                    OP_INV: begin
                        bus = regs_q[ry];
                        g_d = ~regs_q[ry];
                        t_d = T2;
                    end
                    OP_FLP: begin
                        bus = regs_q[ry];
                        g_d = bit_rev(regs_q[ry]);
                        t_d = T2;
                    end
                    default: begin
                        t_d    = T0;
                        done_d = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        bus = regs_q[ry];
                        g_d = add_sub(a_q, alu_b, op[0]);
                        t_d = T3;
                    end
                    OP_ADDI, OP_SUBI: begin
                        bus = D;
                        if (EXEC) begin
                            g_d = add_sub(a_q, alu_b, op[0]);
                            t_d = T3;
                        end
                    end
                    OP_INV, OP_FLP: begin
                        bus        = g_q;
                        regs_d[rx] = g_q;
                        t_d        = T0;
                        done_d     = 1'b1;
                    end
                    default: t_d = T0;
                endcase
            end
            T3: begin
                bus        = g_q;
                regs_d[rx] = g_q;
                t_d        = T0;
                done_d     = 1'b1;
            end
            default: t_d = T0;
        endcase
    end

    // State registers; reset clears everything and aborts any instruction.
    always_ff @(posedge CLK) begin
        if (!CLRn) begin
            t_q    <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            t_q    <= t_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            g_q    <= g_d;
            done_q <= done_d;
            regs_q <= regs_d;
        end
    end

`ifdef FLAGS_EN
    logic [2:0] flags_q, flags_d;
    logic       carry;

    // Flags follow every G load; C is carry-out for add, not-borrow for subtract.
    always_comb begin
        flags_d = flags_q;
        carry   = 1'b0;
        if (t_q == T1 && (op == OP_INV || op == OP_FLP)) begin
            flags_d = {g_d[W-1], 1'b0, g_d == '0};
        end else if (t_q == T2 && (op == OP_ADD || op == OP_SUB ||
                                   ((op == OP_ADDI || op == OP_SUBI) && EXEC))) begin
            carry   = op[0] ? (a_q >= alu_b) : (g_d < a_q);
            flags_d = {g_d[W-1], carry, g_d == '0};
        end
    end

    // Flag register.
    always_ff @(posedge CLK) begin
        if (!CLRn) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign FLAGS = flags_q;
`else
    assign FLAGS = '0;
`endif

    assign PEEK_DATA = regs_q[PEEK_ADDR];
    assign BUS       = bus;
    assign T         = t_q;
    assign BUSY      = (t_q != T0);
    assign DONE      = done_q;

endmodule

// File: tb/tb_proc_core_param.sv
// Testbench for proc_core_param (W=10, NREG=4): directed sequences followed by
// random instructions. A behavioural model predicts each retirement. The
// monitor checks every DONE pulse against the queued prediction.
module tb_proc_core_param;
    localparam int W    = 10;
    localparam int NREG = 4;

    logic         clk = 1'b0;
    logic         CLRn;
    logic         EXEC;
    logic [W-1:0] D;
    logic [1:0]   PEEK_ADDR;
    logic [W-1:0] PEEK_DATA;
    logic [W-1:0] BUS;
    logic [1:0]   T;
    logic         BUSY;
    logic         DONE;
    logic [2:0]   FLAGS;

    always #5 clk = ~clk;

    proc_core_param #(.W(W), .NREG(NREG)) dut (
        .CLK(clk), .CLRn(CLRn), .EXEC(EXEC), .D(D),
        .PEEK_ADDR(PEEK_ADDR), .PEEK_DATA(PEEK_DATA),
        .BUS(BUS), .T(T), .BUSY(BUSY), .DONE(DONE), .FLAGS(FLAGS)
    );

    typedef struct {
        int                         cyc;
        logic [2:0]                 flags;
        logic [NREG-1:0][W-1:0]     regs;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] mdl_r [NREG];
    logic [2:0]   mdl_f;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every DONE pulse must match the oldest prediction.
    always @(negedge clk) begin : mon
        exp_t e;
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual DONE=1 required DONE=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_t", 32'(T), 32'd0);
                chk("done_flags", 32'(FLAGS), 32'(e.flags));
                for (int i = 0; i < NREG; i++) begin
                    PEEK_ADDR = 2'(i);
                    #1;
                    chk($sformatf("done_r%0d", i), 32'(PEEK_DATA), 32'(e.regs[i]));
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mdl_r[i] = '0;
        mdl_f = '0;
    endtask

    // Checks the all-zero state, then advances to just after the next edge.
    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_t"}, 32'(T), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_bus"}, 32'(BUS), 32'd0);
        chk({tag, "_flags"}, 32'(FLAGS), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            PEEK_ADDR = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(PEEK_DATA), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction starting in a T0 cycle (idle or DONE cycle).
    task automatic issue(input int op, input int rx, input int ry, input logic [W-1:0] opnd,
                         input int waits, input int gap);
        logic [W-1:0] a, b, x, res, instr, bus_exp;
        logic         wr;
        logic [2:0]   f;
        int           n, pre;
        bit           has_opnd, is_wait;
        exp_t         e;

        for (int g = 0; g < gap; g++) begin
            EXEC = 1'b0;
            @(negedge clk);
            chk("idle_bus", 32'(BUS), 32'd0);
            chk("idle_busy", 32'(BUSY), 32'd0);
            @(posedge clk);
            #1;
        end

        a   = mdl_r[rx];
        b   = mdl_r[ry];
        x   = (op >= 6) ? opnd : b;
        wr  = 1'b1;
        res = '0;
        case (op)
            0:       res = opnd;
            1:       res = b;
            2, 6:    res = a + x;
            3, 7:    res = a - x;
            4:       res = ~b;
            5:       for (int i = 0; i < W; i++) res[i] = b[W-1-i];
            default: wr = 1'b0;
        endcase
        if (op >= 2 && op <= 7) begin
            f[0] = (res == '0);
            f[2] = res[W-1];
            if (op == 2 || op == 6)      f[1] = (int'(a) + int'(x)) >= (1 << W);
            else if (op == 3 || op == 7) f[1] = (a >= x);
            else                         f[1] = 1'b0;
            mdl_f = f;
        end
        if (wr) mdl_r[rx] = res;
        bus_exp = (op == 0) ? opnd : ((op == 1) ? b : res);

        has_opnd = (op == 0 || op == 6 || op == 7);
        pre      = (op == 0) ? 0 : 1;
        case (op)
            0:       n = waits + 1;
            2, 3:    n = 3;
            4, 5:    n = 2;
            6, 7:    n = waits + 3;
            default: n = 1;
        endcase

        e.cyc = cyc + n + 1;
        for (int i = 0; i < NREG; i++) e.regs[i] = mdl_r[i];
`ifdef FLAGS_EN
        e.flags = mdl_f;
`else
        e.flags = 3'b000;
`endif
        sb.push_back(e);

        instr = {4'(op), 2'(rx), 2'(ry), 2'b00};
        EXEC  = 1'b1;
        D     = instr;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            is_wait = has_opnd && i >= pre && i < pre + waits;
            if (is_wait) begin
                EXEC = 1'b0;
                D    = W'($urandom);
            end else if (has_opnd && i == pre + waits) begin
                EXEC = 1'b1;
                D    = opnd;
            end else begin
                EXEC = 1'($urandom);
                D    = W'($urandom);
            end
            @(negedge clk);
            if (is_wait) begin
                chk("wait_busy", 32'(BUSY), 32'd1);
                chk("wait_t", 32'(T), (op == 0) ? 32'd1 : 32'd2);
            end
            if (i == n - 1 && op < 8) chk("wb_bus", 32'(BUS), 32'(bus_exp));
            @(posedge clk);
            #1;
        end
        EXEC = 1'b0;
    endtask

    initial begin
        int op;
        CLRn      = 1'b0;
        EXEC      = 1'b0;
        D         = '0;
        PEEK_ADDR = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        CLRn = 1'b1;

        // Directed sequence.
        issue(0, 1, 0, 10'h155, 0, 1);   // LOAD R1 = 0x155
        issue(2, 1, 1, 10'h000, 0, 0);   // ADD R1,R1 -> 0x2AA (back-to-back)
        issue(2, 1, 1, 10'h000, 0, 0);   // ADD R1,R1 -> 0x154 (wraps)
        issue(3, 0, 1, 10'h000, 0, 1);   // SUB R0,R1 -> 0x2AC
        issue(0, 2, 0, 10'h001, 2, 0);   // LOAD R2 = 1 after two wait cycles
        issue(5, 2, 2, 10'h000, 0, 0);   // FLP R2 -> 0x200
        issue(4, 2, 2, 10'h000, 0, 2);   // INV R2 -> 0x1FF
        issue(0, 3, 0, 10'h001, 0, 0);   // LOAD R3 = 1
        issue(6, 3, 0, 10'h3FF, 5, 0);   // ADDI R3 with 5 wait cycles -> 0
        issue(7, 3, 0, 10'h001, 1, 0);   // SUBI R3 -> 0x3FF
        issue(3, 2, 2, 10'h000, 0, 0);   // SUB R2,R2 -> 0
        issue(1, 0, 1, 10'h000, 0, 0);   // MOV R0 <- R1
        issue(11, 1, 2, 10'h000, 0, 0);  // undefined op: no write

        // Reset during ADD T2 must abort without writeback.
        EXEC = 1'b1;
        D    = {4'd2, 2'd1, 2'd1, 2'b00};
        @(posedge clk);
        #1;
        EXEC = 1'b0;
        @(posedge clk);
        #1;
        CLRn = 1'b0;
        @(negedge clk);
        chk("pre_rst_t", 32'(T), 32'd2);
        @(posedge clk);
        #1;
        CLRn = 1'b1;
        model_reset();
        check_zero("mid_rst");
        check_zero("post_rst");

        // Random instruction stream.
        repeat (300) begin
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15))
                                             : int'($urandom_range(0, 7));
            issue(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), W'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
